mem_stage: RTL

Load/store unit that sits directly after `ex_stage` in the pipeline. It takes the effective address (`alu_result`), store data (`rs2_val`), opcode and funct3 of LOAD/STORE instructions. It drives a request/grant/response data-memory bus with byte-lane alignment, then returns sign- or zero-extended load data to writeback. One access is in flight at a time, and `ex_ready` back-pressures the execute stage while it is active.

---
 rtl/mem_stage.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: load/store unit between ex_stage and writeback.
// Accepts one LOAD/STORE at a time, drives a req/gnt/rvalid data-memory bus
// with byte-lane alignment, and returns extended load data to writeback.
// Misaligned or illegal-funct3 accesses raise a one-cycle lsu_err instead.
module mem_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [6:0]      ex_opcode,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_addr,
    input  logic [XLEN-1:0] ex_wdata,
    input  logic [4:0]      ex_rd,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [31:0]     dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [31:0]     dmem_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            lsu_err,
    output logic [XLEN-1:0] lsu_err_addr
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t state;
    state_t next_state;

    logic        is_load;
    logic        is_store;
    logic        illegal;
    logic        misaligned;
    logic        acc_err;
    logic        accept;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;

    logic [2:0]  ld_funct3_q;
    logic [1:0]  ld_off_q;
    logic [4:0]  rd_q;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_ext;

    // The execute stage may only hand over an instruction while we are idle.
    assign ex_ready = (state == IDLE) && !rst;

    // Decode the incoming instruction: kind, legality, alignment and store lanes.
    always_comb begin
        is_load    = (ex_opcode == OP_LOAD);
        is_store   = (ex_opcode == OP_STORE);
        illegal    = 1'b0;
        misaligned = 1'b0;
        be_next    = 4'b1111;
        wdata_next = 32'h0;

        if (is_load) begin
            illegal = (ex_funct3 == 3'b011) || (ex_funct3[2:1] == 2'b11);
        end else begin
            illegal = (ex_funct3 >= 3'b011);
        end

        case (ex_funct3[1:0])
            2'b01:   misaligned = ex_addr[0];
            2'b10:   misaligned = (ex_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase

        if (is_store) begin
            case (ex_funct3)
                3'b000: begin
                    be_next    = 4'b0001 << ex_addr[1:0];
                    wdata_next = {4{ex_wdata[7:0]}};
                end
                3'b001: begin
                    be_next    = ex_addr[1] ? 4'b1100 : 4'b0011;
                    wdata_next = {2{ex_wdata[15:0]}};
                end
                default: begin
                    be_next    = 4'b1111;
                    wdata_next = ex_wdata[31:0];
                end
            endcase
        end

        acc_err = illegal || misaligned;
        accept  = (state == IDLE) && ex_valid && (is_load || is_store);
    end

    // Pick the addressed byte/half out of the returned word and extend it.
    always_comb begin
        load_byte = 8'(dmem_rdata >> {ld_off_q, 3'b000});
        load_half = 16'(dmem_rdata >> {ld_off_q[1], 4'b0000});
        case (ld_funct3_q)
            3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_ext = {24'h0, load_byte};
            3'b001:  load_ext = {{16{load_half[15]}}, load_half};
            3'b101:  load_ext = {16'h0, load_half};
            default: load_ext = dmem_rdata;
        endcase
    end

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: stores finish at grant, loads wait for read data.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept && !acc_err) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    next_state = dmem_we ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Registered bus request, writeback and error outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_be      <= 4'b0000;
            dmem_wdata   <= 32'h0;
            wb_valid     <= 1'b0;
            wb_rd        <= 5'd0;
            wb_data      <= '0;
            lsu_err      <= 1'b0;
            lsu_err_addr <= '0;
            ld_funct3_q  <= 3'b000;
            ld_off_q     <= 2'b00;
            rd_q         <= 5'd0;
        end else begin
            wb_valid <= 1'b0;
            lsu_err  <= 1'b0;

            if (accept) begin
                if (acc_err) begin
                    lsu_err      <= 1'b1;
                    lsu_err_addr <= ex_addr;
                end else begin
                    dmem_req    <= 1'b1;
                    dmem_we     <= is_store;
                    dmem_addr   <= {ex_addr[XLEN-1:2], 2'b00};
                    dmem_be     <= be_next;
                    dmem_wdata  <= wdata_next;
                    ld_funct3_q <= ex_funct3;
                    ld_off_q    <= ex_addr[1:0];
                    rd_q        <= ex_rd;
                end
            end

            if ((state == REQ) && dmem_gnt) begin
                dmem_req <= 1'b0;
            end

            if ((state == WAIT) && dmem_rvalid) begin
                wb_valid <= 1'b1;
                wb_rd    <= rd_q;
                wb_data  <= load_ext;
            end
        end
    end

endmodule
